// File: rtl/memoria_pkg.sv
// memoria_pkg -- shared definitions for the sequential data memory.
//   BYTE / MEIA / PALAVRA : DataType encodings (01 byte, 10 halfword, 00 word;
//                           11 is also treated as a full word)
//   estado_t              : access FSM states
//   tamanho()             : access size in bytes for a DataType and lane count
package memoria_pkg;

  localparam logic [1:0] BYTE    = 2'b01;
  localparam logic [1:0] MEIA    = 2'b10;
  localparam logic [1:0] PALAVRA = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } estado_t;

  // Any encoding other than byte/halfword means a full word.
  function automatic int tamanho(input logic [1:0] tipo, input int lanes);
    case (tipo)
      BYTE:    return 1;
      MEIA:    return 2;
      default: return lanes;
    endcase
  endfunction

endpackage

// File: rtl/banco_bytes.sv
// banco_bytes -- one 8-bit lane of the data memory.
//   clock    : rising-edge clock
//   we       : write enable for this lane
//   re       : read enable; rdata holds its value while low
//   endereco : word index
//   wdata    : byte to write
//   rdata    : registered read byte (old contents on a same-cycle write)
module banco_bytes #(
  parameter int DEPTH_W = 8
) (
  input  logic               clock,
  input  logic               we,
  input  logic               re,
  input  logic [DEPTH_W-1:0] endereco,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem [2**DEPTH_W];

  // NOTE: the array and its read register have no reset so the memory maps
  // onto block RAM; contents are undefined until written.
  always_ff @(posedge clock) begin
    if (we) mem[endereco] <= wdata;
    if (re) rdata <= mem[endereco];
  end

endmodule

// File: rtl/memoria_de_dados_seq.sv
// memoria_de_dados_seq -- byte-addressable data memory with a small access FSM.
// Byte/halfword/word loads and stores at any byte address, little-endian.
// An access that straddles two words is split over two bank cycles when the
// macro MEMORIA_DESALINHADO_EN is defined; otherwise it is rejected (erro).
//   clock    : clock, rising edge
//   reset    : synchronous, active-high
//   req      : access request, sampled only in IDLE
//   EscMen   : 1 = write, 0 = read
//   DataType : 01 byte, 10 halfword, 00/11 word
//   Sinal    : 1 = sign-extend byte/halfword loads
//   addr     : byte address
//   data     : write data, right-justified
//   saida    : load result, right-justified; updated only on a read ack
//   ack      : one-cycle completion pulse
//   busy     : high whenever the FSM is not in IDLE
//   erro     : pulses with ack on a rejected access
module memoria_de_dados_seq
  import memoria_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  EscMen,
  input  logic [1:0]            DataType,
  input  logic                  Sinal,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] saida,
  output logic                  ack,
  output logic                  busy,
  output logic                  erro
);

  localparam int LANES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int WORD_W = ADDR_WIDTH - OFF_W;
`ifdef MEMORIA_DESALINHADO_EN
  localparam int MASK_W = 2 * LANES;  // lower half: word w, upper half: word w+1
`else
  localparam int MASK_W = LANES;
`endif

  estado_t estado, proxEstado;

  logic                  regWrite, regSinal;
  logic [1:0]            regTipo;
  logic [ADDR_WIDTH-1:0] regAddr;
  logic [DATA_WIDTH-1:0] regData;

  logic [OFF_W-1:0]      offset;
  logic [WORD_W-1:0]     palavra;
  int                    tam;
  logic                  cruza, rejeita;
  logic [MASK_W-1:0]     mascara;
  logic [DATA_WIDTH-1:0] dadoRot, bancoOut, juntado, rot, leitura;
  logic [LANES-1:0]      bancoWe;
  logic                  bancoRe;
  logic [WORD_W-1:0]     bancoEnd;

  assign offset  = regAddr[OFF_W-1:0];
  assign palavra = regAddr[ADDR_WIDTH-1:OFF_W];

  // Access geometry: size, boundary crossing, lane enables and write data
  // rotated so byte k of the access lands on lane (offset + k) mod LANES.
  always_comb begin
    tam   = tamanho(regTipo, LANES);
    cruza = (int'(offset) + tam) > LANES;
    for (int j = 0; j < MASK_W; j++)
      mascara[j] = (j >= int'(offset)) && (j < int'(offset) + tam);
    for (int j = 0; j < LANES; j++)
      dadoRot[j*8 +: 8] = regData[((j + LANES - int'(offset)) % LANES)*8 +: 8];
  end

`ifdef MEMORIA_DESALINHADO_EN
  assign rejeita = 1'b0;
`else
  assign rejeita = cruza;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) estado <= IDLE;
    else       estado <= proxEstado;
  end

  // Next-state logic.
  // NOTE: proxEstado gets a default first so no path leaves it unassigned,
  // which would infer a latch.
  always_comb begin
    proxEstado = estado;
    case (estado)
      IDLE: if (req) proxEstado = ACC1;
`ifdef MEMORIA_DESALINHADO_EN
      ACC1: proxEstado = cruza ? ACC2 : DONE;
      ACC2: proxEstado = DONE;
`else
      ACC1: proxEstado = DONE;
`endif
      DONE:    proxEstado = IDLE;
      default: proxEstado = IDLE;
    endcase
  end

  // Output / bank-control logic.
  always_comb begin
    busy     = (estado != IDLE);
    bancoWe  = '0;
    bancoRe  = 1'b0;
    bancoEnd = palavra;
    case (estado)
      ACC1: begin
        bancoRe = 1'b1;
        if (regWrite && !rejeita) bancoWe = mascara[LANES-1:0];
      end
`ifdef MEMORIA_DESALINHADO_EN
      ACC2: begin
        bancoRe  = 1'b1;
        bancoEnd = palavra + WORD_W'(1);  // wraps modulo depth
        if (regWrite) bancoWe = mascara[2*LANES-1:LANES];
      end
`endif
      default: ;
    endcase
    // A reset edge must not commit a pending write (abandons an ACC2 half).
    if (reset) bancoWe = '0;
  end

  for (genvar g = 0; g < LANES; g++) begin : gLane
    banco_bytes #(.DEPTH_W(WORD_W)) uBanco (
      .clock    (clock),
      .we       (bancoWe[g]),
      .re       (bancoRe),
      .endereco (bancoEnd),
      .wdata    (dadoRot[g*8 +: 8]),
      .rdata    (bancoOut[g*8 +: 8])
    );
  end

`ifdef MEMORIA_DESALINHADO_EN
  // Word w is overwritten in the bank read register by word w+1 during ACC2,
  // so hold it here; only its lanes at or above the offset are used.
  logic [DATA_WIDTH-1:0] primeira;
  always_ff @(posedge clock) begin
    if (estado == ACC2) primeira <= bancoOut;
  end
`endif

  // Load path: merge the two halves, rotate down by the offset, extend.
  always_comb begin
    juntado = bancoOut;
`ifdef MEMORIA_DESALINHADO_EN
    if (cruza)
      for (int j = 0; j < LANES; j++)
        if (j >= int'(offset)) juntado[j*8 +: 8] = primeira[j*8 +: 8];
`endif
    for (int k = 0; k < LANES; k++)
      rot[k*8 +: 8] = juntado[((k + int'(offset)) % LANES)*8 +: 8];
    case (tam)
      1:       leitura = {{(DATA_WIDTH-8){regSinal & rot[7]}}, rot[7:0]};
      2:       leitura = {{(DATA_WIDTH-16){regSinal & rot[15]}}, rot[15:0]};
      default: leitura = rot;
    endcase
  end

  // Request capture: fields are frozen at acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      regWrite <= 1'b0;
      regSinal <= 1'b0;
      regTipo  <= PALAVRA;
      regAddr  <= '0;
      regData  <= '0;
    end else if (estado == IDLE && req) begin
      regWrite <= EscMen;
      regSinal <= Sinal;
      regTipo  <= DataType;
      regAddr  <= addr;
      regData  <= data;
    end
  end

  // Completion: ack/erro pulse one cycle after DONE; saida only on read acks.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack   <= 1'b0;
      erro  <= 1'b0;
      saida <= '0;
    end else begin
      ack  <= (estado == DONE);
      erro <= (estado == DONE) && rejeita;
      if (estado == DONE && !regWrite && !rejeita) saida <= leitura;
    end
  end

endmodule
